// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to short-circuit zero-operand multiplies and zero dividends.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [2:0]          op, op_nx;
  logic [XLEN-1:0]     opnd, opnd_nx;
  logic [2*XLEN-1:0]   acc, acc_nx;
  logic [XLEN:0]       rem, rem_nx;
  logic                neg_q, neg_q_nx;
  logic                neg_r, neg_r_nx;
  logic [XLEN-1:0]     result_nx;

  logic                accept;
  logic                a_sgn, b_sgn;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                is_div, div0, ovf;
  logic                sp_hit;
  logic [XLEN-1:0]     sp_val;

  logic [XLEN:0]       sum;
  logic [2*XLEN-1:0]   mul_step;
  logic [XLEN+1:0]     shl, diff;
  logic                ge;
  logic [XLEN:0]       rem_step;
  logic [XLEN-1:0]     quo_step;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rmd, fin;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid & req_ready & ~flush;
  assign stall      = (state == RUN) | (state == DONE) | accept;
  assign resp_valid = (state == DONE) & ~flush;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (Funct3)
      3'b001,
      3'b100,
      3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010: a_sgn = 1'b1;
      default: ;
    endcase
  end

  // -2^31 negates to itself, which is already the right unsigned magnitude
  assign a_neg = a_sgn & operand_a[XLEN-1];
  assign b_neg = b_sgn & operand_b[XLEN-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  assign is_div = Funct3[2];
  assign div0   = is_div & (operand_b == '0);
  assign ovf    = is_div & ~Funct3[0]
                & (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                & (&operand_b);

  always_comb begin
    sp_hit = 1'b0;
    sp_val = '0;
    if (div0) begin
      sp_hit = 1'b1;
      sp_val = Funct3[1] ? operand_a : '1;
    end else if (ovf) begin
      sp_hit = 1'b1;
      sp_val = Funct3[1] ? '0 : operand_a;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (~is_div & ((operand_a == '0) | (operand_b == '0))) begin
      sp_hit = 1'b1;
      sp_val = '0;
    end else if (is_div & (operand_a == '0)) begin
      sp_hit = 1'b1;
      sp_val = '0;
    end
`endif
  end

  // multiply: high half accumulates, low half shifts the multiplier out
  assign sum      = {1'b0, acc[2*XLEN-1:XLEN]}
                  + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {sum, acc[XLEN-1:1]};

  // divide: low half of acc shifts dividend in, quotient bits out
  assign shl      = {rem, acc[XLEN-1]};
  assign diff     = shl - {2'b00, opnd};
  assign ge       = ~diff[XLEN+1];
  assign rem_step = ge ? diff[XLEN:0] : shl[XLEN:0];
  assign quo_step = {acc[XLEN-2:0], ge};

  assign prod = neg_q ? -mul_step : mul_step;
  assign quo  = neg_q ? -quo_step : quo_step;
  assign rmd  = neg_r ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];

  always_comb begin
    fin = '0;
    unique case (op)
      3'b000:        fin = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:        fin = prod[2*XLEN-1:XLEN];
      3'b100,
      3'b101:        fin = quo;
      3'b110,
      3'b111:        fin = rmd;
      default:       fin = '0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    op_nx     = op;
    opnd_nx   = opnd;
    acc_nx    = acc;
    rem_nx    = rem;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;
    result_nx = result;
    unique case (state)
      IDLE: begin
        if (accept) begin
          op_nx    = Funct3;
          cnt_nx   = '0;
          rem_nx   = '0;
          neg_q_nx = a_neg ^ b_neg;
          neg_r_nx = a_neg;
          if (is_div) begin
            opnd_nx = b_mag;
            acc_nx  = {{XLEN{1'b0}}, a_mag};
          end else begin
            opnd_nx = a_mag;
            acc_nx  = {{XLEN{1'b0}}, b_mag};
          end
          if (sp_hit) begin
            state_nx  = DONE;
            result_nx = sp_val;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (op[2]) begin
          acc_nx = {acc[2*XLEN-1:XLEN], quo_step};
          rem_nx = rem_step;
        end else begin
          acc_nx = mul_step;
        end
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(XLEN-1)) begin
          state_nx  = DONE;
          result_nx = fin;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx  = IDLE;
      result_nx = result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      op     <= op_nx;
      opnd   <= opnd_nx;
      acc    <= acc_nx;
      rem    <= rem_nx;
      neg_q  <= neg_q_nx;
      neg_r  <= neg_r_nx;
      result <= result_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
// Early-out expectations follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  Funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .Funct3     (Funct3),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flush      (flush),
    .stall      (stall),
    .resp_valid (resp_valid),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int elat);
    int   lat;
    logic st_ok;
    logic rdy_ok;
    @(negedge clk);
    req_valid = 1'b1;
    Funct3    = f;
    operand_a = a;
    operand_b = b;
    #1;
    chk({tag, "/rdy0"}, 32'(req_ready), 32'd1);
    chk({tag, "/stall0"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    operand_a = ~a;
    operand_b = ~b;
    Funct3    = ~f;
    lat    = 0;
    st_ok  = 1'b1;
    rdy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!stall) st_ok = 1'b0;
      if (req_ready) rdy_ok = 1'b0;
    end while (!resp_valid && lat < 40);
    chk({tag, "/lat"}, 32'(lat), 32'(elat));
    chk({tag, "/res"}, result, exp);
    chk({tag, "/stall"}, 32'(st_ok), 32'd1);
    chk({tag, "/busy"}, 32'(rdy_ok), 32'd1);
    @(negedge clk);
    chk({tag, "/rdy1"}, 32'(req_ready), 32'd1);
    chk({tag, "/vld1"}, 32'(resp_valid), 32'd0);
    last_res = exp;
  endtask

  task automatic no_resp(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int eo_lat;
`ifdef MULDIV_EARLY_OUT_EN
    eo_lat = 1;
`else
    eo_lat = 33;
`endif
    reset     = 1'b1;
    req_valid = 1'b0;
    Funct3    = 3'b000;
    operand_a = '0;
    operand_b = '0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst/rdy", 32'(req_ready), 32'd1);
    chk("rst/stall", 32'(stall), 32'd0);
    chk("rst/vld", 32'(resp_valid), 32'd0);
    chk("rst/res", result, 32'd0);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 33);
    run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0000, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,
           32'hFFFF_FFFF, 33);
    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 33);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu0", 3'b111, 32'd9, 32'd0, 32'd9, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1);
    run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 33);

    // flush ten cycles into a divide
    @(negedge clk);
    req_valid = 1'b1;
    Funct3    = 3'b100;
    operand_a = 32'd100;
    operand_b = 32'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush/rdy", 32'(req_ready), 32'd1);
    chk("flush/vld", 32'(resp_valid), 32'd0);
    chk("flush/res", result, last_res);
    no_resp("flush/quiet");

    // flush beats a request in IDLE
    @(negedge clk);
    req_valid = 1'b1;
    flush     = 1'b1;
    Funct3    = 3'b000;
    operand_a = 32'd3;
    operand_b = 32'd5;
    #1;
    chk("fidle/stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    chk("fidle/rdy", 32'(req_ready), 32'd1);
    chk("fidle/res", result, last_res);

    // reset in the middle of a multiply
    @(negedge clk);
    req_valid = 1'b1;
    Funct3    = 3'b000;
    operand_a = 32'd3;
    operand_b = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst/rdy", 32'(req_ready), 32'd1);
    chk("mrst/stall", 32'(stall), 32'd0);
    chk("mrst/vld", 32'(resp_valid), 32'd0);
    chk("mrst/res", result, 32'd0);
    no_resp("mrst/quiet");

    run_op("mul_zero", 3'b000, 32'd0, 32'h1234_5678, 32'd0, eo_lat);
    run_op("mulhu_2p32", 3'b011, 32'h0001_0000, 32'h0001_0000,
           32'd1, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
